uart_xintf_bridge: RTL and testbench
====================================

# uart_xintf_bridge

Parametrised UART-to-XINTF bus bridge, successor to the fixed 16-bit `uart_xintf` block. It decodes framed command bytes from the UART receiver into single XINTF read or write cycles on zone 6 or zone 7, with programmable lead, active and trail phase lengths. It returns a response (write acknowledge, read data or error) to the UART transmitter over a valid/ready handshake. It sits between `uart_rx`/`uart_tx` and the external XINTF pins.

## Interface
Parameters:
- `ADDR_W`, 16, XINTF address width, 1..24.
- `DATA_W`, 16, XINTF data width; one of 8, 16, 24, 32. `DATA_BYTES = DATA_W/8`.
- `LEAD`, 2, lead-phase cycles, ≥1.
- `ACTIVE`, 3, active-phase cycles (strobe low), ≥1.
- `TRAIL`, 1, trail-phase cycles, ≥1.
- `TIMEOUT`, 1000, maximum idle cycles between bytes of one frame, ≥2.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: received-byte strobe; may be high for more than one cycle.
- `rx_data_in` in 8: received byte.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte valid.
- `tx_ready` in 1: transmitter accepts the byte.
- `xa` out ADDR_W: XINTF address.
- `xd` inout DATA_W: XINTF data. Driven only during write cycles, Z otherwise.
- `xwen` out 1: write strobe, active-low.
- `xrdn` out 1: read strobe, active-low.
- `zone_6_n` out 1: zone 6 chip select, active-low.
- `zone_7_n` out 1: zone 7 chip select, active-low.
- `busy` out 1: high in any state other than IDLE.
- `rx_overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- **Byte acceptance:** a byte is accepted on a rising edge of `rx_valid`, i.e. `rx_valid`=1 and its registered copy is 0. A strobe held high for multiple cycles counts as one byte.
- **Frame format:**
  - command byte: `'w'` (0x77) or `'r'` (0x72);
  - 4 address bytes, MSB first, forming A[31:0];
  - for `'w'` only, `DATA_BYTES` data bytes, MSB first.
- **Address decode:**
  - A[31:24]=0x00 selects zone 6; 0x01 selects zone 7; any other value is an error.
  - `xa` = A[ADDR_W-1:0]. Bits A[23:ADDR_W] are ignored.
- **States:** IDLE, ADDR, WDATA, LEAD, ACT, TRAIL, RESP, ERR.
  - IDLE: a valid command goes to ADDR. Any other command byte goes to ERR.
  - ADDR: after the 4th address byte, go to WDATA for a write, or LEAD for a read. A bad zone goes to ERR instead (for a write, only after all data bytes are received, via WDATA).
  - WDATA: after the last data byte, go to LEAD (or ERR on a bad zone).
  - LEAD → ACT → TRAIL: each phase lasts its parameter count of cycles. TRAIL then goes to RESP.
  - RESP: presents the response bytes, then returns to IDLE.
  - ERR: presents 0x3F (`'?'`), then returns to IDLE.
- **Bus cycle:**
  - Zone select and `xa` are asserted from the first LEAD cycle through the last TRAIL cycle.
  - `xwen` (write) or `xrdn` (read) is low only during ACT.
  - On a write, `xd` is driven with the assembled data from LEAD through TRAIL.
  - On a read, `xd` is sampled on the clock edge that ends the final ACT cycle.
- **Responses:**
  - write: a single byte 0x4B (`'K'`);
  - read: `DATA_BYTES` bytes of sampled data, MSB first.
- **Frame timeout:** in ADDR or WDATA, if `TIMEOUT` cycles pass without an accepted byte, the FSM returns silently to IDLE with no response.
- **Dropped bytes:** a byte arriving in LEAD, ACT, TRAIL, RESP or ERR is dropped and `rx_overrun` pulses.

## Timing
- **Reset values:** `xa`=0, `xd`=Z, `xwen`=`xrdn`=`zone_6_n`=`zone_7_n`=1, `tx_valid`=0, `tx_data`=0, `busy`=0, `rx_overrun`=0, FSM in IDLE, frame counters cleared.
- **Reset mid-operation:** all outputs return to their reset values immediately, asynchronously, including de-assertion of strobes and chip selects.
- **Bus start latency:** the first LEAD cycle begins on the clock edge after the final frame byte is accepted.
- **Total bus length:** `LEAD + ACTIVE + TRAIL` cycles. The zone select de-asserts on the edge that enters RESP.
- **Response timing:**
  - `tx_valid` rises on the first RESP or ERR cycle.
  - `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0.
  - A byte transfers on a clock edge where `tx_valid` and `tx_ready` are both 1. The next byte, if any, is presented on the following cycle.
  - After the last transfer, `tx_valid` drops and the FSM enters IDLE.
- **Simultaneous events:** if the timeout expires on the same cycle a byte is accepted, the byte wins and the timeout counter reloads.
- **Counters:**
  - phase counters count down from parameter−1 to 0;
  - the byte counter counts 0..3 for address, then 0..`DATA_BYTES`−1 for data, and clears on every entry to IDLE.

## Test plan
- **Write, zone 7:** `'w'`, 01 00 10 00, 0A A0 with 2-cycle `rx_valid` strobes → `zone_7_n` low for 6 cycles; `xa`=0x1000; `xd`=0x0AA0; `xwen` low for 3 cycles starting 2 cycles after `zone_7_n` falls; `tx` 0x4B; each byte counted once.
- **Read, zone 6:** `'r'`, 00 00 00 42, bench drives `xd`=0xBEEF during ACT → `zone_6_n` low; `xrdn` low for 3 cycles; `xd` Z from the bridge; `tx` 0xBE then 0xEF.
- **Errors:** `'x'` → `tx` 0x3F with no bus activity. `'r'`, 02 00 00 00 → `tx` 0x3F, no zone asserted.
- **Timeout:** `'w'`, 01 00, then idle for 1000 cycles → `busy` falls, no `tx`. A following `'r'` frame completes normally.
- **Backpressure and overrun:** read response with `tx_ready` held low for 10 cycles → `tx_data` stable at the MSB byte. A byte sent during ACT → `rx_overrun` pulses once and the bus cycle is unaffected.
- **Reset mid-cycle:** reset asserted during ACT of a write → `xwen`, `zone_7_n` and `xd` return to 1/1/Z in the same cycle, asynchronously. The next frame after reset release completes normally.

Source files
------------

// File: rtl/uart_xintf_bridge.sv
// uart_xintf_bridge: decodes UART command frames into single XINTF zone 6/7 read/write cycles
// and returns a write ack, read data or '?' error byte over a valid/ready handshake.
module uart_xintf_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LEAD    = 2,
    parameter int ACTIVE  = 3,
    parameter int TRAIL   = 1,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] xa,
    inout  wire  [DATA_W-1:0] xd,
    output logic              xwen,
    output logic              xrdn,
    output logic              zone_6_n,
    output logic              zone_7_n,
    output logic              busy,
    output logic              rx_overrun
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PMAX = (LEAD > ACTIVE) ? ((LEAD > TRAIL) ? LEAD : TRAIL)
                                          : ((ACTIVE > TRAIL) ? ACTIVE : TRAIL);
    localparam int PW = $clog2(PMAX) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, LEAD_S, ACT, TRAIL_S, RESP, ERR} state_t;

    state_t            state, next;
    logic              rx_valid_q, wr;
    logic [1:0]        byte_cnt;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic [PW-1:0]     phase_cnt;
    logic [TW-1:0]     to_cnt;
    logic              accept, in_frame, bus, phase_done, timeout, last_data, last_resp;
    logic [31:0]       a_next;

    assign accept     = rx_valid && !rx_valid_q;
    assign in_frame   = state == ADDR || state == WDATA;
    assign bus        = state == LEAD_S || state == ACT || state == TRAIL_S;
    assign phase_done = phase_cnt == '0;
    assign timeout    = to_cnt == TW'(TIMEOUT - 1);
    assign last_data  = byte_cnt == 2'(DATA_BYTES - 1);
    assign last_resp  = wr || last_data;
    assign a_next     = {addr[23:0], rx_data_in};
    assign xd         = (bus && wr) ? wdata : 'z;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = (rx_data_in == 8'h77 || rx_data_in == 8'h72) ? ADDR : ERR;
            ADDR:    if (accept) begin
                         if (byte_cnt == 2'd3) next = wr ? WDATA : (a_next[31:25] != '0 ? ERR : LEAD_S);
                     end else if (timeout) next = IDLE;
            WDATA:   if (accept) begin
                         if (last_data) next = addr[31:25] != '0 ? ERR : LEAD_S;
                     end else if (timeout) next = IDLE;
            LEAD_S:  if (phase_done) next = ACT;
            ACT:     if (phase_done) next = TRAIL_S;
            TRAIL_S: if (phase_done) next = RESP;
            RESP:    if (tx_ready && last_resp) next = IDLE;
            ERR:     if (tx_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Zone is only ever entered with A[31:25]=0, so A[24] alone picks zone 6 or 7.
    always_comb begin
        xa       = bus ? addr[ADDR_W-1:0] : '0;
        zone_6_n = !(bus && !addr[24]);
        zone_7_n = !(bus && addr[24]);
        xwen     = !(state == ACT && wr);
        xrdn     = !(state == ACT && !wr);
        tx_valid = state == RESP || state == ERR;
        tx_data  = state == ERR ? 8'h3F : state == RESP ? (wr ? 8'h4B : rdata[DATA_W-1 -: 8]) : 8'h00;
        busy     = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            rx_overrun <= 1'b0;
            wr         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            rdata      <= '0;
            byte_cnt   <= '0;
            phase_cnt  <= '0;
            to_cnt     <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            rx_overrun <= accept && (bus || state == RESP || state == ERR);
            if (state == IDLE && accept) wr <= rx_data_in == 8'h77;
            if (state == ADDR && accept) addr <= a_next;
            if (state == WDATA && accept) wdata <= DATA_W'({wdata, rx_data_in});
            if (state == ACT && phase_done) rdata <= xd;
            else if (state == RESP && tx_ready) rdata <= rdata << 8;
            byte_cnt <= (next != state) ? '0
                      : ((in_frame && accept) || (state == RESP && tx_ready)) ? byte_cnt + 2'd1 : byte_cnt;
            phase_cnt <= (next != state) ? (next == LEAD_S ? PW'(LEAD - 1) : next == ACT ? PW'(ACTIVE - 1)
                                          : next == TRAIL_S ? PW'(TRAIL - 1) : '0)
                       : bus ? phase_cnt - PW'(1) : phase_cnt;
            to_cnt <= (accept || !in_frame) ? '0 : to_cnt + TW'(1);
        end
    end
endmodule

// File: tb/tb_uart_xintf_bridge.sv
// tb_uart_xintf_bridge: directed frames against the default 16-bit bridge with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_xintf_bridge;
    logic        clk = 1'b0, reset = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0]  rx_data_in = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid, xwen, xrdn, zone_6_n, zone_7_n, busy, rx_overrun;
    logic [15:0] xa;
    wire  [15:0] xd;
    logic        rd_auto = 1'b1, force_drv = 1'b0;
    logic [15:0] tb_val = 16'h0000;

    always #5 clk = ~clk;
    assign xd = ((rd_auto && !xrdn) || force_drv) ? tb_val : 'z;

    uart_xintf_bridge dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data_in(rx_data_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .xa(xa), .xd(xd),
        .xwen(xwen), .xrdn(xrdn), .zone_6_n(zone_6_n), .zone_7_n(zone_7_n),
        .busy(busy), .rx_overrun(rx_overrun)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0, z6 = 0, z7 = 0, wen = 0, rdn = 0, ovr = 0, z7_start = 0, wen_start = 0;
    int z6_0, z7_0, wen_0, rdn_0, ovr_0;
    logic z7_prev = 1'b0, wen_prev = 1'b0;
    logic [15:0] last_xa = '0, last_wd = '0;
    logic [7:0] txq[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!zone_6_n) begin z6 <= z6 + 1; last_xa <= xa; end
        if (!zone_7_n) begin z7 <= z7 + 1; last_xa <= xa; if (!z7_prev) z7_start <= cyc; end
        if (!xwen) begin wen <= wen + 1; last_wd <= xd; if (!wen_prev) wen_start <= cyc; end
        if (!xrdn) rdn <= rdn + 1;
        if (rx_overrun) ovr <= ovr + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        z7_prev <= !zone_7_n;
        wen_prev <= !xwen;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        z6_0 = z6; z7_0 = z7; wen_0 = wen; rdn_0 = rdn; ovr_0 = ovr;
    endtask

    task automatic send(input logic [7:0] b, input int len);
        rx_data_in = b;
        rx_valid = 1'b1;
        repeat (len) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [63:0] f, input int n, input int len);
        for (int i = n - 1; i >= 0; i--) send(f[8*i +: 8], len);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && txq.size() < n; i++) @(posedge clk);
        #1 check("tx_count", txq.size(), n);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        b = (txq.size() > 0) ? txq.pop_front() : 8'hxx;
        check(tag, b, exp);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
        check("idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_xa", xa, 0);
        check("rst_strobes", {xwen, xrdn, zone_6_n, zone_7_n}, 4'hF);
        check("rst_overrun", rx_overrun, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        snap();
        send_frame(64'h77_01001000_0AA0, 7, 2);
        wait_tx(1);
        expect_tx("wr_ack", 8'h4B);
        wait_idle();
        check("wr_zone7_cycles", z7 - z7_0, 6);
        check("wr_zone6_cycles", z6 - z6_0, 0);
        check("wr_xwen_cycles", wen - wen_0, 3);
        check("wr_xwen_offset", wen_start - z7_start, 2);
        check("wr_xa", last_xa, 16'h1000);
        check("wr_xd", last_wd, 16'h0AA0);
        check("wr_no_overrun", ovr - ovr_0, 0);

        snap();
        tb_val = 16'hBEEF;
        send_frame(64'h72_00000042, 5, 1);
        wait_tx(2);
        expect_tx("rd_msb", 8'hBE);
        expect_tx("rd_lsb", 8'hEF);
        wait_idle();
        check("rd_zone6_cycles", z6 - z6_0, 6);
        check("rd_zone7_cycles", z7 - z7_0, 0);
        check("rd_xrdn_cycles", rdn - rdn_0, 3);
        check("rd_xwen_cycles", wen - wen_0, 0);
        check("rd_xa", last_xa, 16'h0042);

        snap();
        tb_val = 16'hA55A;
        tx_ready = 1'b0;
        send_frame(64'h72_00000034, 5, 1);
        for (int i = 0; i < 20 && xrdn; i++) begin @(posedge clk); #1; end
        check("ovr_act_seen", xrdn, 0);
        send(8'h55, 1);
        for (int i = 0; i < 50 && !tx_valid; i++) begin @(posedge clk); #1; end
        check("bp_valid", tx_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {tx_valid, tx_data}, {1'b1, 8'hA5});
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_tx(2);
        expect_tx("bp_msb", 8'hA5);
        expect_tx("bp_lsb", 8'h5A);
        wait_idle();
        check("ovr_pulses", ovr - ovr_0, 1);
        check("ovr_xrdn_cycles", rdn - rdn_0, 3);
        check("ovr_zone6_cycles", z6 - z6_0, 6);

        snap();
        send(8'h78, 1);
        wait_tx(1);
        expect_tx("err_cmd", 8'h3F);
        wait_idle();
        check("err_cmd_bus", (z6 - z6_0) + (z7 - z7_0) + (wen - wen_0) + (rdn - rdn_0), 0);

        snap();
        send_frame(64'h72_02000000, 5, 1);
        wait_tx(1);
        expect_tx("err_zone", 8'h3F);
        wait_idle();
        check("err_zone_bus", (z6 - z6_0) + (z7 - z7_0) + (rdn - rdn_0), 0);

        send_frame(64'h77_0100, 3, 1);
        repeat (998) @(posedge clk);
        #1 check("to_busy_before", busy, 1);
        @(posedge clk); #1;
        check("to_busy_after", busy, 0);
        check("to_no_tx", txq.size(), 0);
        snap();
        tb_val = 16'h1357;
        send_frame(64'h72_00000042, 5, 1);
        wait_tx(2);
        expect_tx("to_rd_msb", 8'h13);
        expect_tx("to_rd_lsb", 8'h57);
        wait_idle();
        check("to_rd_xrdn_cycles", rdn - rdn_0, 3);

        send_frame(64'h77_01001000_0AA0, 7, 1);
        for (int i = 0; i < 20 && xwen; i++) begin @(posedge clk); #1; end
        check("rst_act_seen", xwen, 0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_strobes", {xwen, zone_7_n, busy, tx_valid}, 4'b1100);
        tb_val = 16'h5555;
        force_drv = 1'b1;
        #1 check("rst_xd_released", xd, 16'h5555);
        force_drv = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        txq.delete();
        snap();
        send_frame(64'h77_01002000_1234, 7, 1);
        wait_tx(1);
        expect_tx("post_rst_ack", 8'h4B);
        wait_idle();
        check("post_rst_zone7", z7 - z7_0, 6);
        check("post_rst_xa", last_xa, 16'h2000);
        check("post_rst_xd", last_wd, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
